data_mem_stage: RTL

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

---
 rtl/data_mem_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/data_mem_stage.sv
// rtl/data_mem_stage.sv - two-cycle data memory stage with sub-word access and alignment checks
// A 1024-word byte-lane memory: each aligned access stalls the pipe for one cycle and completes at IDLE->BUSY.
module data_mem_stage (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemSize,
   input  logic        MemSigned,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AddrError
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [31:0] mem [0:1023] = '{default: 32'h0000_0000};

   logic        is_byte;
   logic        is_half;
   logic        is_word;
   logic        misaligned;
   logic        req;
   logic        start;
   logic [9:0]  word_idx;
   logic [31:0] rd_word;
   logic [31:0] lane_mask;
   logic [31:0] store_data;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^Address[31:12];

   assign is_byte    = (MemSize == 2'b10);
   assign is_half    = (MemSize == 2'b01);
   assign is_word    = !is_byte && !is_half;
   assign misaligned = (is_half && Address[0]) || (is_word && (Address[1:0] != 2'b00));
   assign req        = MemRead || MemWrite;
   assign word_idx   = Address[11:2];
   assign rd_word    = mem[word_idx];

   always_comb begin
      lane_mask  = 32'hFFFF_FFFF;
      store_data = WriteData;
      if (is_byte) begin
         lane_mask  = 32'h0000_00FF << {Address[1:0], 3'b000};
         store_data = {4{WriteData[7:0]}};
      end else if (is_half) begin
         lane_mask  = Address[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
         store_data = {2{WriteData[15:0]}};
      end
   end

   always_comb begin
      byte_sel = rd_word[7:0];
      case (Address[1:0])
         2'b00:   byte_sel = rd_word[7:0];
         2'b01:   byte_sel = rd_word[15:8];
         2'b10:   byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = Address[1] ? rd_word[31:16] : rd_word[15:0];

      load_val = rd_word;
      if (is_byte) begin
         load_val = MemSigned ? {{24{byte_sel[7]}}, byte_sel} : {24'h00_0000, byte_sel};
      end else if (is_half) begin
         load_val = MemSigned ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
      end
   end

   // Reset masks every request so nothing starts, stalls or flags on a reset cycle.
   always_comb begin
      state_nxt = state;
      Stall     = 1'b0;
      AddrError = 1'b0;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (req && !Reset) begin
               if (misaligned) begin
                  AddrError = 1'b1;
               end else begin
                  Stall     = 1'b1;
                  start     = 1'b1;
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         ReadData <= 32'h0000_0000;
      end else begin
         state <= state_nxt;
         if (start && MemRead && !MemWrite) begin
            ReadData <= load_val;
         end
      end
   end

   // A combined read+write request behaves as a store only.
   always_ff @(posedge Clk) begin
      if (start && MemWrite) begin
         mem[word_idx] <= (rd_word & ~lane_mask) | (store_data & lane_mask);
      end
   end

endmodule
